// File: rtl/audio_player_ctrl.sv
//------------------------------------------------------------------------------
// Module      : audio_player_ctrl
// Description : Streams a ROM clip to a downstream stage at one sample per
//               SAMPLE_DIV clocks, with looping, abort and overrun reporting.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module audio_player_ctrl #(
    parameter int unsigned SAMPLE_DIV = 1250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [13:0] start_addr,
    input  logic [13:0] end_addr,
    output logic [13:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t      state_q,    state_d;
    logic [15:0] div_cnt_q,  div_cnt_d;
    logic [13:0] la_start_q, la_start_d;
    logic [13:0] la_end_q,   la_end_d;
    logic [13:0] rom_addr_q, rom_addr_d;
    logic [15:0] sample_q,   sample_d;
    logic        valid_q,    valid_d;
    logic        done_q,     done_d;
    logic        overrun_q,  overrun_d;
    logic        tick;

    assign tick = (state_q == ST_PLAY) && (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        la_start_d = la_start_q;
        la_end_d   = la_end_q;
        rom_addr_d = rom_addr_q;
        sample_d   = sample_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;

        // An accepted sample frees the output register; a tick below may refill it.
        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop && (start_addr <= end_addr)) begin
                    la_start_d = start_addr;
                    la_end_d   = end_addr;
                    rom_addr_d = start_addr;
                    div_cnt_d  = 16'd0;
                    overrun_d  = 1'b0;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                    div_cnt_d = 16'd0;
                end else if (tick) begin
                    div_cnt_d = 16'd0;
                    sample_d  = rom_data;
                    valid_d   = 1'b1;
                    if (valid_q && !sample_ready) begin
                        overrun_d = 1'b1;
                    end
                    if (rom_addr_q != la_end_q) begin
                        rom_addr_d = rom_addr_q + 14'd1;
                    end else if (loop_en) begin
                        rom_addr_d = la_start_q;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= 16'd0;
            la_start_q <= 14'd0;
            la_end_q   <= 14'd0;
            rom_addr_q <= 14'd0;
            sample_q   <= 16'd0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            la_start_q <= la_start_d;
            la_end_q   <= la_end_d;
            rom_addr_q <= rom_addr_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q == ST_PLAY);
    assign done         = done_q;
    assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_player_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_audio_player_ctrl
// Description : Directed self-checking bench for audio_player_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_audio_player_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [13:0] start_addr;
    logic [13:0] end_addr;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    audio_player_ctrl #(.SAMPLE_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    assign rom_data = {2'b00, rom_addr} + 16'h1000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are sampled and inputs driven 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [13:0] sa, input logic [13:0] ea, input logic lp);
        start_addr = sa;
        end_addr   = ea;
        loop_en    = lp;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        start_addr = 14'd5;
        end_addr   = 14'd9;
        repeat (2) step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b valid=%b done=%b ovr=%b, required all 0",
                     busy, sample_valid, done, overrun);
        end
        n_checks++;
        if (rom_addr !== 14'd0 || sample_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: rom_addr=%0d sample_out=%h, required 0/0000", rom_addr, sample_out);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_oneshot();
        logic [15:0] exp_data [3];
        exp_data[0] = 16'h100A;
        exp_data[1] = 16'h100B;
        exp_data[2] = 16'h100C;
        launch(14'd10, 14'd12, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || rom_addr !== 14'd10) begin
            n_fail++;
            $display("FAIL oneshot_start: busy=%b rom_addr=%0d, required 1/10", busy, rom_addr);
        end
        for (int k = 0; k < 3; k++) begin
            repeat (3) step();
            n_checks++;
            if (sample_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL oneshot_early_%0d: sample_valid=%b, required 0", k, sample_valid);
            end
            step();
            n_checks++;
            if (sample_valid !== 1'b1 || sample_out !== exp_data[k] || done !== (k == 2)) begin
                n_fail++;
                $display("FAIL oneshot_sample_%0d: valid=%b data=%h done=%b, required 1/%h/%b",
                         k, sample_valid, sample_out, done, exp_data[k], (k == 2));
            end
        end
        n_checks++;
        if (busy !== 1'b0 || rom_addr !== 14'd12) begin
            n_fail++;
            $display("FAIL oneshot_end: busy=%b rom_addr=%0d, required 0/12", busy, rom_addr);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || sample_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_after: done=%b valid=%b busy=%b, required 0/0/0", done, sample_valid, busy);
        end
    endtask

    task automatic test_loop();
        logic [15:0] exp_data [8];
        logic        saw_done;
        exp_data = '{16'h100A, 16'h100B, 16'h100C, 16'h100A, 16'h100B, 16'h100C, 16'h100A, 16'h100B};
        saw_done = 1'b0;
        launch(14'd10, 14'd12, 1'b1);
        for (int k = 0; k < 8; k++) begin
            repeat (3) begin
                step();
                saw_done = saw_done | done;
            end
            step();
            saw_done = saw_done | done;
            n_checks++;
            if (sample_valid !== 1'b1 || sample_out !== exp_data[k] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL loop_sample_%0d: valid=%b data=%h busy=%b, required 1/%h/1",
                         k, sample_valid, sample_out, busy, exp_data[k]);
            end
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_done: done seen=%b, required 0", saw_done);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_stop: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_overrun();
        launch(14'd10, 14'd12, 1'b1);
        repeat (4) step();
        sample_ready = 1'b0;
        repeat (4) step();
        n_checks++;
        if (overrun !== 1'b1 || sample_out !== 16'h100B || sample_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: ovr=%b data=%h valid=%b, required 1/100b/1",
                     overrun, sample_out, sample_valid);
        end
        repeat (2) step();
        sample_ready = 1'b1;
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b0 || sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_sticky: ovr=%b busy=%b valid=%b, required 1/0/0",
                     overrun, busy, sample_valid);
        end
        launch(14'd10, 14'd12, 1'b0);
        n_checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b busy=%b, required 0/1", overrun, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_stop_on_tick();
        launch(14'd10, 14'd12, 1'b0);
        repeat (4) step();
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sample_out !== 16'h100A) begin
            n_fail++;
            $display("FAIL stop_tick: valid=%b busy=%b done=%b data=%h, required 0/0/0/100a",
                     sample_valid, busy, done, sample_out);
        end
    endtask

    task automatic test_bounds();
        launch(14'd20, 14'd19, 1'b0);
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_range: busy=%b, required 0", busy);
        end
        start = 1'b1;
        stop  = 1'b1;
        start_addr = 14'd1;
        end_addr   = 14'd2;
        step();
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_stop: busy=%b, required 0", busy);
        end
        launch(14'd16383, 14'd16383, 1'b0);
        repeat (3) step();
        step();
        n_checks++;
        if (sample_valid !== 1'b1 || sample_out !== 16'h4FFF || done !== 1'b1 ||
            busy !== 1'b0 || rom_addr !== 14'd16383) begin
            n_fail++;
            $display("FAIL top_addr: valid=%b data=%h done=%b busy=%b addr=%0d, required 1/4fff/1/0/16383",
                     sample_valid, sample_out, done, busy, rom_addr);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL top_addr_after: done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic test_reset_midplay();
        sample_ready = 1'b0;
        launch(14'd10, 14'd12, 1'b1);
        repeat (4) step();
        n_checks++;
        if (sample_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midplay_pre: valid=%b busy=%b, required 1/1", sample_valid, busy);
        end
        rst_n = 1'b0;
        start = 1'b1;
        step();
        n_checks++;
        if (sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 ||
            rom_addr !== 14'd0 || sample_out !== 16'd0) begin
            n_fail++;
            $display("FAIL midplay_reset: valid=%b busy=%b done=%b ovr=%b addr=%0d data=%h, required all 0",
                     sample_valid, busy, done, overrun, rom_addr, sample_out);
        end
        step();
        rst_n = 1'b1;
        start = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midplay_start_ignored: busy=%b, required 0", busy);
        end
        sample_ready = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        loop_en      = 1'b0;
        start_addr   = 14'd0;
        end_addr     = 14'd0;
        sample_ready = 1'b1;
        step();
        test_reset();
        test_oneshot();
        test_loop();
        test_overrun();
        test_stop_on_tick();
        test_bounds();
        test_reset_midplay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/audio_player_ctrl.md
AUDIO_PLAYER_CTRL -- requirements
Module: audio_player_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 1250, meaning clock cycles per output sample; legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin playback, sampled each cycle.
REQ-005 The block SHALL have port stop  input  1  request to abort playback.
REQ-006 The block SHALL have port loop_en  input  1  when 1 at the end address, playback restarts at the latched start address.
REQ-007 The block SHALL have port start_addr  input  14  first ROM address of the clip, latched on accepted start.
REQ-008 The block SHALL have port end_addr  input  14  last ROM address of the clip (inclusive), latched on accepted start.
REQ-009 The block SHALL have port rom_addr  output  14  address to the combinational 16384x16 audio ROM.
REQ-010 The block SHALL have port rom_data  input  16  ROM read data, valid in the same cycle as rom_addr.
REQ-011 The block SHALL have port sample_out  output  16  registered sample to the downstream DAC/PWM stage.
REQ-012 The block SHALL have port sample_valid  output  1  sample_out holds an unconsumed sample.
REQ-013 The block SHALL have port sample_ready  input  1  the downstream stage accepts sample_out when sample_valid=1.
REQ-014 The block SHALL have port busy  output  1  1 while in state PLAY.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse when a non-looping clip completes.
REQ-016 The block SHALL have port overrun  output  1  sticky flag: a sample was overwritten before acceptance.

Function
REQ-017 The block SHALL implement two states, IDLE and PLAY, plus a 16-bit divider counter div_cnt and the registers la_start and la_end.
REQ-018 In IDLE, start=1, stop=0 and start_addr<=end_addr SHALL latch la_start/la_end, set rom_addr=start_addr, set div_cnt=0, clear overrun, and enter PLAY at that edge.
REQ-019 In IDLE, a start with start_addr>end_addr, or a start with stop=1 in the same cycle, SHALL be ignored.
REQ-020 In PLAY, div_cnt SHALL increment every cycle and wrap to 0 after SAMPLE_DIV-1 (the tick cycle).
REQ-021 On a tick edge, sample_out SHALL load rom_data and sample_valid SHALL be set to 1, so the first sample is valid SAMPLE_DIV edges after the start edge.
REQ-022 On a tick edge, if rom_addr!=la_end, rom_addr SHALL increment by 1.
REQ-023 On a tick edge with rom_addr==la_end and loop_en=1, rom_addr SHALL reload la_start and the block SHALL stay in PLAY.
REQ-024 On a tick edge with rom_addr==la_end and loop_en=0, the block SHALL enter IDLE and pulse done for exactly one cycle; rom_addr SHALL hold la_end.
REQ-025 A clip with la_start==la_end SHALL play exactly one sample (or that sample repeatedly when loop_en=1).
REQ-026 An edge with sample_valid=1 and sample_ready=1 SHALL clear sample_valid, unless the same edge is a tick, in which case sample_valid stays 1 with new data and overrun is not set.
REQ-027 A tick with sample_valid=1 and sample_ready=0 SHALL overwrite sample_out and set overrun to 1; overrun SHALL stay 1 until reset or the next accepted start.
REQ-028 stop=1 in PLAY SHALL enter IDLE at that edge with no capture (stop wins over a simultaneous tick), clear sample_valid, and leave done at 0.
REQ-029 start in PLAY SHALL be ignored, and a change to loop_en SHALL take effect at the next end-address tick.
REQ-030 A pending sample SHALL remain valid in IDLE until it is accepted.
REQ-031 rom_addr SHALL never exceed la_end, so no 14-bit wrap-around occurs.

Reset
REQ-032 rst_n=0 at an edge SHALL force IDLE, div_cnt=0, rom_addr=0, sample_out=0, sample_valid=0, busy=0, done=0, overrun=0, la_start=0 and la_end=0, overriding all other inputs including a mid-playback state.

Verification (SAMPLE_DIV=4, ROM model rom[a]=a+16'h1000, sample_ready=1 unless stated)
REQ-033 Bench SHALL cover: start_addr=10, end_addr=12, loop_en=0 -> samples 0x100A, 0x100B, 0x100C at 4-cycle spacing, first one 4 edges after start; done pulses 1 cycle with the third sample; then busy=0.
REQ-034 Bench SHALL cover: the same clip with loop_en=1 for 8 ticks -> sequence 0x100A, 0x100B, 0x100C, 0x100A, ...; done never asserts.
REQ-035 Bench SHALL cover: sample_ready=0 for 6 cycles during playback -> overrun=1 and sample_out holds the newest sample; a later start clears overrun.
REQ-036 Bench SHALL cover: stop asserted on a tick cycle -> no new sample, sample_valid=0, busy=0 and done=0 on the next cycle.
REQ-037 Bench SHALL cover: start with start_addr=20, end_addr=19 -> remains IDLE with busy=0; start with end_addr=16383 and start_addr=16383 -> one sample 0x4FFF, then done.
REQ-038 Bench SHALL cover: rst_n=0 mid-PLAY with sample_valid=1 -> all outputs 0 after that edge, and start is ignored while rst_n=0.
